// File: rtl/l3_req_arbiter_if.sv
// Bundle of requester-side and L3-controller-side signals around l3_req_arbiter.
// slave = arbiter view, master = requesters plus controller (environment) view.
interface l3_req_arbiter_if #(
   parameter int DATA_LENGTH = 32,
   parameter int NUM_REQ     = 2
);
   localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]             req_valid;
   logic [NUM_REQ-1:0]             req_we;
   logic [NUM_REQ*32-1:0]          req_addr;
   logic [NUM_REQ*DATA_LENGTH-1:0] req_wdata;
   logic [NUM_REQ-1:0]             req_done;
   logic [NUM_REQ-1:0]             req_err;
   logic [DATA_LENGTH-1:0]         req_rdata;
   logic [IDW-1:0]                 grant_id;
   logic                           busy;

   logic                           l3_load_valid;
   logic                           l3_store_valid;
   logic [31:0]                    l3_addr;
   logic [DATA_LENGTH-1:0]         l3_store_data;
   logic                           l3_done;
   logic [DATA_LENGTH-1:0]         l3_rdata;

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, l3_done, l3_rdata,
      output req_done, req_err, req_rdata, grant_id, busy,
             l3_load_valid, l3_store_valid, l3_addr, l3_store_data
   );

   modport master (
      output req_valid, req_we, req_addr, req_wdata, l3_done, l3_rdata,
      input  req_done, req_err, req_rdata, grant_id, busy,
             l3_load_valid, l3_store_valid, l3_addr, l3_store_data
   );
endinterface

// File: rtl/l3_req_arbiter.sv
// Round-robin arbiter sharing one L3 controller port among NUM_REQ requesters.
// Define L3_ARB_TIMEOUT_EN to add a watchdog that aborts an access after TIMEOUT_CYCLES.

module l3_req_arbiter_lane #(
   parameter int ID  = 0,
   parameter int IDW = 1
) (
   input  logic           resp,
   input  logic           err,
   input  logic [IDW-1:0] grant_id,
   output logic           done,
   output logic           err_pulse
);
   logic sel;
   assign sel       = (grant_id == IDW'(ID));
   assign done      = resp & sel;
   assign err_pulse = resp & err & sel;
endmodule

module l3_req_arbiter #(
   parameter int DATA_LENGTH    = 32,
   parameter int NUM_REQ        = 2,
   parameter int TIMEOUT_CYCLES = 255
) (
   input logic             clk,
   input logic             rst,
   l3_req_arbiter_if.slave bus
);
   localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [IDW-1:0]         rr_ptr, grant_q, win_id, cand;
   logic                   found;
   logic                   we_q, err_q, to_hit;
   logic [31:0]            addr_q;
   logic [DATA_LENGTH-1:0] wdata_q, rdata_q;
   logic                   load_v, store_v, resp;

   logic [31:0]            addr_arr  [NUM_REQ];
   logic [DATA_LENGTH-1:0] wdata_arr [NUM_REQ];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
         assign addr_arr[gi]  = bus.req_addr[gi*32 +: 32];
         assign wdata_arr[gi] = bus.req_wdata[gi*DATA_LENGTH +: DATA_LENGTH];
         l3_req_arbiter_lane #(.ID(gi), .IDW(IDW)) u_lane (
            .resp      (resp),
            .err       (err_q),
            .grant_id  (grant_q),
            .done      (bus.req_done[gi]),
            .err_pulse (bus.req_err[gi])
         );
      end
   endgenerate

   // Walk downward so the candidate closest to rr_ptr is the last one written.
   always_comb begin
      found  = 1'b0;
      win_id = '0;
      cand   = '0;
      for (int k = NUM_REQ-1; k >= 0; k--) begin
         cand = IDW'((int'(rr_ptr) + k) % NUM_REQ);
         if (bus.req_valid[cand]) begin
            found  = 1'b1;
            win_id = cand;
         end
      end
   end

`ifdef L3_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] to_cnt;

   // Counts completed ISSUE cycles; zero in the first ISSUE cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         to_cnt <= '0;
      else if (state_q == ISSUE)
         to_cnt <= to_cnt + CW'(1);
      else
         to_cnt <= '0;
   end

   assign to_hit = (state_q == ISSUE) && (to_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
   // Watchdog compiled out; the parameter stays so both builds share one port list.
   assign to_hit = (TIMEOUT_CYCLES < 0);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      load_v  = 1'b0;
      store_v = 1'b0;
      resp    = 1'b0;
      case (state_q)
         IDLE: begin
            if (found)
               state_d = ISSUE;
         end
         ISSUE: begin
            load_v  = !we_q;
            store_v = we_q;
            if (bus.l3_done || to_hit)
               state_d = RESP;
         end
         RESP: begin
            resp    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr  <= '0;
         grant_q <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         if (state_q == IDLE && found) begin
            grant_q <= win_id;
            we_q    <= bus.req_we[win_id];
            addr_q  <= addr_arr[win_id];
            wdata_q <= wdata_arr[win_id];
         end
         if (state_q == ISSUE) begin
            if (bus.l3_done) begin
               rdata_q <= we_q ? '0 : bus.l3_rdata;
               err_q   <= 1'b0;
            end else if (to_hit) begin
               rdata_q <= '0;
               err_q   <= 1'b1;
            end
         end
         if (state_q == RESP)
            rr_ptr <= (grant_q == IDW'(NUM_REQ - 1)) ? '0 : grant_q + IDW'(1);
      end
   end

   assign bus.l3_load_valid  = load_v;
   assign bus.l3_store_valid = store_v;
   assign bus.l3_addr        = addr_q;
   assign bus.l3_store_data  = wdata_q;
   assign bus.req_rdata      = resp ? rdata_q : '0;
   assign bus.grant_id       = grant_q;
   assign bus.busy           = (state_q != IDLE);
endmodule

// File: tb/tb_l3_req_arbiter.sv
// Scoreboard bench for l3_req_arbiter: one process drives requesters, models the L3
// controller and checks completions against queued expectations.
module tb_l3_req_arbiter;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   l3_req_arbiter_if #(.DATA_LENGTH(32), .NUM_REQ(2)) bif ();

   l3_req_arbiter #(.DATA_LENGTH(32), .NUM_REQ(2), .TIMEOUT_CYCLES(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   typedef struct {
      bit          id;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      bit          err;
      int          lat;
      bit          last;
   } exp_t;

   exp_t        sb[$];
   int          n_chk = 0, n_pass = 0;
   int          l3_lat = 1, mcnt = 0, vcnt = 0;
   bit          l3_hang = 1'b0, spur = 1'b0, prev_v = 1'b0;
   bit          keep [2];
   logic [31:0] t_addr [2];
   logic [31:0] t_wdata [2];

   function automatic logic [31:0] data_fn(input logic [31:0] a);
      return (a == 32'h0000_1000) ? 32'hFFFF_FFFF : (~a ^ 32'h1234_5678);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
   endtask

   task automatic drive(input bit id, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
      t_addr[id]        = addr;
      t_wdata[id]       = wdata;
      bif.req_we[id]    = we;
      bif.req_addr      = {t_addr[1], t_addr[0]};
      bif.req_wdata     = {t_wdata[1], t_wdata[0]};
      bif.req_valid[id] = 1'b1;
   endtask

   task automatic expect_txn(input bit id, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                             input int lat, input bit err, input bit last);
      exp_t e;
      e.id = id; e.we = we; e.addr = addr; e.wdata = wdata;
      e.rdata = (we || err) ? 32'h0 : data_fn(addr);
      e.err = err; e.lat = lat; e.last = last;
      sb.push_back(e);
   endtask

   task automatic issue(input bit id, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input int lat, input bit err);
      drive(id, we, addr, wdata);
      expect_txn(id, we, addr, wdata, lat, err, 1'b0);
   endtask

   // L3 controller: raises l3_done after l3_lat valid cycles, for one cycle.
   task automatic model();
      if (bif.l3_done) begin
         bif.l3_done = 1'b0; bif.l3_rdata = '0; mcnt = 0;
      end else if (spur) begin
         bif.l3_done = 1'b1; bif.l3_rdata = 32'hCAFE_0001; spur = 1'b0;
      end else if ((bif.l3_load_valid || bif.l3_store_valid) && !l3_hang) begin
         mcnt++;
         if (mcnt >= l3_lat) begin
            bif.l3_done = 1'b1; bif.l3_rdata = data_fn(bif.l3_addr);
         end
      end
   endtask

   task automatic monitor();
      bit          v;
      exp_t        e;
      logic [1:0]  oh;
      v = bif.l3_load_valid | bif.l3_store_valid;
      if (v && !prev_v) begin
         vcnt = 1;
         if (sb.size() == 0) chk("unexpected_issue", 64'(sb.size()), 64'(1));
         else begin
            e = sb[0];
            chk("grant_id", 64'(bif.grant_id), 64'(e.id));
            chk("l3_addr", 64'(bif.l3_addr), 64'(e.addr));
            chk("kind", 64'({bif.l3_load_valid, bif.l3_store_valid}), e.we ? 64'd1 : 64'd2);
            if (e.we) chk("l3_store_data", 64'(bif.l3_store_data), 64'(e.wdata));
         end
      end else if (v) vcnt++;
      if (bif.req_done != 2'b00) begin
         if (sb.size() == 0) chk("unexpected_done", 64'(bif.req_done), 64'(0));
         else begin
            e  = sb.pop_front();
            oh = 2'b01 << e.id;
            chk("req_done", 64'(bif.req_done), 64'(oh));
            chk("req_err", 64'(bif.req_err), e.err ? 64'(oh) : 64'(0));
            chk("req_rdata", 64'(bif.req_rdata), 64'(e.rdata));
            chk("valid_cycles", 64'(vcnt), 64'(e.lat));
            chk("done_after_issue", 64'(prev_v), 64'(1));
            if (e.last) keep[e.id] = 1'b0;
            if (!keep[e.id]) bif.req_valid[e.id] = 1'b0;
         end
      end else if (bif.req_err != 2'b00) chk("stray_err", 64'(bif.req_err), 64'(0));
      prev_v = v;
   endtask

   task automatic tick();
      @(negedge clk);
      if (rst) begin
         bif.l3_done = 1'b0; bif.l3_rdata = '0; mcnt = 0; prev_v = 1'b0; vcnt = 0;
      end else begin
         monitor();
         model();
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while ((sb.size() != 0 || bif.busy) && n < 300);
      if (sb.size() != 0 || bif.busy) chk("wait_idle_timeout", 64'(sb.size()), 64'(0));
   endtask

   initial begin
      rst = 1'b1;
      bif.req_valid = '0; bif.req_we = '0; bif.req_addr = '0; bif.req_wdata = '0;
      bif.l3_done = 1'b0; bif.l3_rdata = '0;
      keep[0] = 1'b0; keep[1] = 1'b0;
      t_addr[0] = '0; t_addr[1] = '0; t_wdata[0] = '0; t_wdata[1] = '0;
      tick();
      chk("rst_ctrl", 64'({bif.busy, bif.l3_load_valid, bif.l3_store_valid, bif.grant_id}), 64'(0));
      chk("rst_done", 64'({bif.req_done, bif.req_err}), 64'(0));
      chk("rst_rdata", 64'(bif.req_rdata), 64'(0));
      chk("rst_bus", 64'({bif.l3_addr, bif.l3_store_data}), 64'(0));
      rst = 1'b0;
      tick();

      // single load, 5-cycle controller latency
      l3_lat = 5; issue(1'b0, 1'b0, 32'h0000_1000, 32'h0, 5, 1'b0); wait_idle();
      // single store from requester 1
      l3_lat = 3; issue(1'b1, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 3, 1'b0); wait_idle();

      // both held for six transactions: grants alternate 0,1,0,1,0,1
      l3_lat = 2; keep[0] = 1'b1; keep[1] = 1'b1;
      for (int k = 0; k < 6; k++) begin
         bit id;
         id = k[0];
         expect_txn(id, id, id ? 32'h0000_3100 : 32'h0000_3000, id ? 32'h1111_2222 : 32'h0,
                    2, 1'b0, bit'(k >= 4));
      end
      drive(1'b0, 1'b0, 32'h0000_3000, 32'h0);
      drive(1'b1, 1'b1, 32'h0000_3100, 32'h1111_2222);
      wait_idle();

      // requester 1 arrives while requester 0 is in ISSUE
      l3_lat = 4; issue(1'b0, 1'b0, 32'h0000_4000, 32'h0, 4, 1'b0);
      tick(); tick();
      issue(1'b1, 1'b0, 32'h0000_5000, 32'h0, 4, 1'b0);
      wait_idle();

      // minimum-latency store
      l3_lat = 1; issue(1'b1, 1'b1, 32'h0000_6000, 32'h0BAD_F00D, 1, 1'b0); wait_idle();

      // l3_done while idle must not start anything
      spur = 1'b1; tick(); tick(); tick();
      chk("idle_done_ignored", 64'({bif.busy, bif.l3_load_valid, bif.l3_store_valid}), 64'(0));

      // leaves rr_ptr at 1 before the reset test
      l3_lat = 2; issue(1'b0, 1'b0, 32'h0000_7000, 32'h0, 2, 1'b0); wait_idle();

      // asynchronous reset in the middle of ISSUE
      l3_hang = 1'b1; issue(1'b1, 1'b0, 32'h0000_8000, 32'h0, 0, 1'b0);
      tick(); tick(); tick();
      #2 rst = 1'b1;
      #1;
      chk("arst_ctrl", 64'({bif.busy, bif.l3_load_valid, bif.l3_store_valid, bif.grant_id}), 64'(0));
      chk("arst_done", 64'({bif.req_done, bif.req_err}), 64'(0));
      chk("arst_bus", 64'({bif.l3_addr, bif.l3_store_data}), 64'(0));
      bif.req_valid = '0; sb.delete(); l3_hang = 1'b0; keep[0] = 1'b0; keep[1] = 1'b0;
      tick(); tick();
      rst = 1'b0;
      drive(1'b1, 1'b0, 32'h0000_9000, 32'h0);
      drive(1'b0, 1'b0, 32'h0000_A000, 32'h0);
      expect_txn(1'b0, 1'b0, 32'h0000_A000, 32'h0, 2, 1'b0, 1'b0);
      expect_txn(1'b1, 1'b0, 32'h0000_9000, 32'h0, 2, 1'b0, 1'b0);
      wait_idle();

`ifdef L3_ARB_TIMEOUT_EN
      // controller never answers: watchdog fires after 8 ISSUE cycles
      l3_hang = 1'b1; issue(1'b0, 1'b0, 32'h0000_B000, 32'h0, 8, 1'b1); wait_idle();
      l3_hang = 1'b0;
`endif

      tick(); tick();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
